// File: rtl/sel0628_pkg.sv
// Shared definitions for the sel0628 accumulator CPU: widths, opcode and ALU
// op encodings, and the fetch/execute/write state machine states.
package sel0628_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // Instruction opcode, bits [7:6]
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_JNZ = 2'b11;

    // ALU operation, bits [5:4] of an ALU instruction
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        WRITE = 2'b10
    } state_e;

endpackage

// File: rtl/sel0628_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with modulo arithmetic and a zero flag.
module sel0628_alu
    import sel0628_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y,
    output logic         zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/sel0628_cpu.sv
// 8-bit accumulator CPU: 4-entry register file, 6-bit PC, zero flag, and a
// FETCH/EXEC/WRITE sequencer driving one shared, registered RAM address bus.
module sel0628_cpu
    import sel0628_pkg::*;
#(
    parameter int ADDR_W = sel0628_pkg::ADDR_W,
    parameter int DATA_W = sel0628_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] data_in,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       pc_q, pc_d;
    logic [DATA_W-1:0]       ir_q, ir_d;
    logic [3:0][DATA_W-1:0]  r_q, r_d;
    logic                    z_q, z_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       dout_q, dout_d;
    logic                    we_q, we_d;

    logic [DATA_W-1:0]       alu_y;
    logic                    alu_zero;
    logic [1:0]              fetch_op;
    logic [1:0]              ir_op;

    assign fetch_op = data_in[7:6];
    assign ir_op    = ir_q[7:6];

    sel0628_alu #(.W(DATA_W)) u_alu (
        .a    (r_q[ir_q[3:2]]),
        .b    (r_q[ir_q[1:0]]),
        .op   (ir_q[5:4]),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // State register; reset also aborts any in-flight write strobe at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            r_q     <= '0;
            z_q     <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            r_q     <= r_d;
            z_q     <= z_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = EXEC;
            EXEC:    state_d = (ir_op == OP_ST) ? WRITE : FETCH;
            WRITE:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Datapath and registered bus outputs. For ALU/JNZ the fetch address is
    // simply held through EXEC; it is replaced by the new PC at EXEC's end.
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        r_d    = r_q;
        z_d    = z_q;
        addr_d = addr_q;
        dout_d = dout_q;
        we_d   = we_q;
        case (state_q)
            FETCH: begin
                ir_d = data_in;
                pc_d = pc_q + ADDR_W'(1);
                if (fetch_op == OP_LD || fetch_op == OP_ST)
                    addr_d = data_in[ADDR_W-1:0];
                if (fetch_op == OP_ST)
                    dout_d = r_q[0];
            end
            EXEC: begin
                case (ir_op)
                    OP_LD: begin
                        r_d[0] = data_in;
                        addr_d = pc_q;
                    end
                    OP_ST: begin
                        we_d = 1'b1;
                    end
                    OP_ALU: begin
                        r_d[ir_q[3:2]] = alu_y;
                        z_d            = alu_zero;
                        addr_d         = pc_q;
                    end
                    default: begin
                        if (!z_q) begin
                            pc_d   = ir_q[ADDR_W-1:0];
                            addr_d = ir_q[ADDR_W-1:0];
                        end else begin
                            addr_d = pc_q;
                        end
                    end
                endcase
            end
            WRITE: begin
                we_d   = 1'b0;
                addr_d = pc_q;
            end
            default: begin
                we_d   = 1'b0;
                addr_d = pc_q;
            end
        endcase
    end

    assign we       = we_q;
    assign addr     = addr_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_sel0628_cpu.sv
// Directed bench for sel0628_cpu with a behavioural 64x8 async-read RAM.
module tb_sel0628_cpu;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] data_in;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data_out;

    logic [7:0] mem [0:63];
    int n_checks = 0;
    int n_fail   = 0;

    sel0628_cpu dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .data_in  (data_in),
        .we       (we),
        .addr     (addr),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    assign data_in = mem[addr];
    always @(posedge clk) if (we) mem[addr] <= data_out;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    initial begin
        logic [5:0] p_addr;
        logic [7:0] p_dout;
        logic       p_we;
        int         jnz_fetches;
        int         found;
        int         extra_we;
        int         bad_addr;

        // ---------------- Program A: LD/ALU basics, loop, store ----------------
        clr_n = 1'b0;
        clear_mem();
        mem[0] = 8'h0F; mem[1] = 8'h95; mem[2] = 8'h84; mem[3] = 8'h85;
        mem[4] = 8'h85; mem[5] = 8'h94; mem[6] = 8'hC5; mem[7] = 8'h4E;
        mem[8] = 8'hA0; mem[9] = 8'hC8; mem[14] = 8'h00; mem[15] = 8'h04;
        #12;
        check("reset_addr", 8'(addr), 8'h00);
        check("reset_we", 8'(we), 8'h00);
        check("reset_dout", data_out, 8'h00);
        check("reset_r0", dut.r_q[0], 8'h00);
        check("reset_z", 8'(dut.z_q), 8'h00);

        @(negedge clk);
        clr_n = 1'b1;
        check("first_fetch_addr", 8'(addr), 8'h00);

        cycles(10);
        check("basics_r0", dut.r_q[0], 8'h04);
        check("basics_r1", dut.r_q[1], 8'h10);
        check("basics_z", 8'(dut.z_q), 8'h00);
        check("basics_addr", 8'(addr), 8'h05);

        p_addr = addr; p_dout = data_out; p_we = we;
        jnz_fetches = 0; found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (we) begin
                found = 1;
            end else begin
                if (addr == 6'd6 && p_addr != 6'd6) jnz_fetches++;
                p_addr = addr; p_dout = data_out; p_we = we;
            end
        end
        check("st_we_seen", 8'(found), 8'h01);
        check("loop_iterations", 8'(jnz_fetches), 8'h04);
        check("loop_r1_final", dut.r_q[1], 8'h00);
        check("st_pre_we", 8'(p_we), 8'h00);
        check("st_pre_addr", 8'(p_addr), 8'h0E);
        check("st_pre_dout", p_dout, 8'h04);
        check("st_addr", 8'(addr), 8'h0E);
        check("st_dout", data_out, 8'h04);

        @(negedge clk);
        check("st_we_fall", 8'(we), 8'h00);
        check("st_mem14", mem[14], 8'h04);
        check("after_st_addr", 8'(addr), 8'h08);

        extra_we = 0; bad_addr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (we) extra_we++;
            if (addr != 6'd8 && addr != 6'd9) bad_addr++;
        end
        check("tight_loop_extra_we", 8'(extra_we), 8'h00);
        check("tight_loop_bad_addr", 8'(bad_addr), 8'h00);

        // ---------------- Program B: reset during WRITE ----------------
        clr_n = 1'b0;
        clear_mem();
        mem[0] = 8'h0F; mem[1] = 8'h4E; mem[15] = 8'h5A;
        @(negedge clk);
        clr_n = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (we) found = 1;
        end
        check("abort_we_seen", 8'(found), 8'h01);
        check("abort_dout_before", data_out, 8'h5A);
        #2 clr_n = 1'b0;
        #1;
        check("abort_we", 8'(we), 8'h00);
        check("abort_addr", 8'(addr), 8'h00);
        check("abort_dout", data_out, 8'h00);
        @(negedge clk);
        check("abort_no_write", mem[14], 8'h00);
        clr_n = 1'b1;
        check("abort_refetch_addr", 8'(addr), 8'h00);
        cycles(1);
        check("abort_first_ld_addr", 8'(addr), 8'h0F);

        // ---------------- Program C: ALU ops, JNZ not taken, PC wrap ----------------
        clr_n = 1'b0;
        clear_mem();
        mem[0]  = 8'h10; mem[1]  = 8'h88; mem[2]  = 8'h11; mem[3]  = 8'h8C;
        mem[4]  = 8'h86; mem[5]  = 8'hA7; mem[6]  = 8'hBB; mem[7]  = 8'h12;
        mem[8]  = 8'h88; mem[9]  = 8'h98; mem[10] = 8'h95; mem[11] = 8'hD4;
        mem[12] = 8'h80; mem[13] = 8'hFF; mem[63] = 8'h80;
        mem[16] = 8'hF0; mem[17] = 8'h0F; mem[18] = 8'h01;
        @(negedge clk);
        clr_n = 1'b1;

        cycles(12);
        check("setup_r2", dut.r_q[2], 8'hF0);
        check("setup_r3", dut.r_q[3], 8'h0F);
        check("and_result", dut.r_q[1], 8'h00);
        check("and_z", 8'(dut.z_q), 8'h01);
        cycles(2);
        check("or_result", dut.r_q[2], 8'hFF);
        check("or_z", 8'(dut.z_q), 8'h00);
        cycles(2);
        check("ld_r0", dut.r_q[0], 8'h01);
        check("ld_keeps_z", 8'(dut.z_q), 8'h00);
        cycles(2);
        check("add_carry_result", dut.r_q[2], 8'h00);
        check("add_carry_z", 8'(dut.z_q), 8'h01);
        cycles(2);
        check("sub_borrow_result", dut.r_q[2], 8'hFF);
        check("sub_borrow_z", 8'(dut.z_q), 8'h00);
        cycles(2);
        check("sub_self_z", 8'(dut.z_q), 8'h01);
        cycles(2);
        check("jnz_not_taken_addr", 8'(addr), 8'h0C);
        check("jnz_keeps_z", 8'(dut.z_q), 8'h01);
        cycles(2);
        check("add_self_r0", dut.r_q[0], 8'h02);
        cycles(2);
        check("jnz_taken_addr", 8'(addr), 8'h3F);
        cycles(2);
        check("pc_wrap_addr", 8'(addr), 8'h00);
        check("pc_wrap_r0", dut.r_q[0], 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
